// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit sequencer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity bit from the XOR-reduction of the data and the parity type.
  function automatic logic parity_bit(input logic red_xor, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~red_xor : red_xor;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Front-end / line-side signal bundle for the UART transmit sequencer.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] P_data;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output data_valid, P_data, PAR_EN, PAR_TYP,
    input  TX_OUT, busy, frame_done
  );

  modport slave (
    input  data_valid, P_data, PAR_EN, PAR_TYP,
    output TX_OUT, busy, frame_done
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// Data latch and bit index for the UART transmitter. The byte is held
// unshifted and the counter selects the bit on the line, so the XOR
// reduction of the latched byte stays valid for the parity slot.
// With UART_TX_TWO_STOP_EN defined the counter also times the second stop bit.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  adv_i,
  input  logic                  clr_i,
  output logic                  ser_bit_o,
  output logic                  ser_next_o,
  output logic                  ser_last_o,
  output logic                  ser_red_o
`ifdef UART_TX_TWO_STOP_EN
  ,
  output logic                  ser_zero_o
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_nxt;

  assign cnt_nxt    = cnt_q + CNT_W'(1);
  assign ser_bit_o  = data_q[cnt_q];
  assign ser_next_o = data_q[cnt_nxt];
  assign ser_last_o = (cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign ser_red_o  = ^data_q;
`ifdef UART_TX_TWO_STOP_EN
  assign ser_zero_o = (cnt_q == '0);
`endif

  // Next-state for the data latch and bit index.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      data_d = data_i;
      cnt_d  = '0;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = cnt_nxt;
    end
  end

  // Data latch and bit index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte in IDLE and sends
// start, LSB-first data, optional parity and stop at one bit per clk.
// Outputs are flops loaded from the next-state decode, so they change
// together with the state and never glitch.
// Optional build macro: UART_TX_TWO_STOP_EN (two stop bits).
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_ctrl_if.slave  bus
);

  state_e state_q, state_d;
  logic   tx_q, tx_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   pe_q, pe_d;
  logic   pt_q, pt_d;
  logic   load, adv, clr;
  logic   ser_bit, ser_next, ser_last, ser_red;
`ifdef UART_TX_TWO_STOP_EN
  logic   ser_zero;
`endif

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .data_i     (bus.P_data),
    .adv_i      (adv),
    .clr_i      (clr),
    .ser_bit_o  (ser_bit),
    .ser_next_o (ser_next),
    .ser_last_o (ser_last),
    .ser_red_o  (ser_red)
`ifdef UART_TX_TWO_STOP_EN
    ,
    .ser_zero_o (ser_zero)
`endif
  );

  // Next state, serializer control and next values of the output flops.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    adv     = 1'b0;
    clr     = 1'b0;
    pe_d    = pe_q;
    pt_d    = pt_q;
    case (state_q)
      IDLE: begin
        if (bus.data_valid) begin
          load    = 1'b1;
          pe_d    = bus.PAR_EN;
          pt_d    = bus.PAR_TYP;
          state_d = START;
        end
      end
      START: state_d = DATA;
      DATA: begin
        if (ser_last) begin
          clr     = 1'b1;
          state_d = pe_q ? PARITY : STOP;
        end else begin
          adv = 1'b1;
        end
      end
      PARITY: state_d = STOP;
      STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        if (ser_zero) begin
          adv = 1'b1;
        end else begin
          clr     = 1'b1;
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Line level for the cycle about to start. On entry to DATA the index
    // is 0; while already in DATA the index advances, so take the next bit.
    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = (state_q == DATA) ? ser_next : ser_bit;
      PARITY:  tx_d = parity_bit(ser_red, pt_q);
      STOP:    tx_d = STOP_BIT;
      default: tx_d = IDLE_LEVEL;
    endcase

    busy_d = (state_d != IDLE);
`ifdef UART_TX_TWO_STOP_EN
    done_d = (state_d == STOP) && (state_q == STOP);
`else
    done_d = (state_d == STOP);
`endif
  end

  // State, latched frame config and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pe_q    <= 1'b0;
      pt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pe_q    <= pe_d;
      pt_q    <= pt_d;
    end
  end

  assign bus.TX_OUT     = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl. Expected line patterns are hand-built:
// bit i of a pattern is TX_OUT in cycle i+1 after the accept edge, and
// bits past the frame are 1 (stop / idle level).
module tb_uart_tx_ctrl;
  import uart_tx_pkg::*;

`ifdef UART_TX_TWO_STOP_EN
  localparam int XSTOP = 1;
`else
  localparam int XSTOP = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vec_cnt = 0;
  int   mis_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " tx"},   32'(bus.TX_OUT),     32'd1);
    chk({tag, " busy"}, 32'(bus.busy),       32'd0);
    chk({tag, " done"}, 32'(bus.frame_done), 32'd0);
  endtask

  // Called at a falling edge with the DUT in IDLE; returns at the falling
  // edge of the IDLE cycle after the frame. With hold=1 data_valid stays
  // high so the next frame is accepted at the end of that IDLE cycle.
  task automatic run_frame(input string name, input logic [7:0] d, input logic pe,
                           input logic pt, input logic [11:0] pat, input bit hold);
    int len;
    len = 10 + int'(pe) + XSTOP;
    bus.P_data     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.data_valid = 1'b1;
    @(negedge clk);
    if (!hold) bus.data_valid = 1'b0;
    for (int c = 1; c <= len; c++) begin
      if (c == 3) begin
        bus.P_data = 8'h3C;
        if (!hold) begin
          bus.PAR_EN  = ~pe;
          bus.PAR_TYP = ~pt;
        end
      end
      chk($sformatf("%s tx c%0d", name, c),   32'(bus.TX_OUT),     32'(pat[c-1]));
      chk($sformatf("%s busy c%0d", name, c), 32'(bus.busy),       32'd1);
      chk($sformatf("%s done c%0d", name, c), 32'(bus.frame_done), 32'(c == len));
      @(negedge clk);
    end
    check_idle({name, " gap"});
  endtask

  initial begin
    rst            = 1'b0;
    bus.data_valid = 1'b0;
    bus.P_data     = 8'h00;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = PAR_EVEN;

    // reset held, then idle line
    repeat (3) begin
      @(negedge clk);
      check_idle("reset");
    end
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_idle("idle");
    end

    // A5 no parity: 0 | 1,0,1,0,0,1,0,1 | 1
    run_frame("a5", 8'hA5, 1'b0, PAR_EVEN, 12'b1111_0100_1010, 1'b0);
    // 03 even parity: 0 | 1,1,0,0,0,0,0,0 | 0 | 1
    run_frame("even", 8'h03, 1'b1, PAR_EVEN, 12'b1100_0000_0110, 1'b0);
    // 03 odd parity: parity bit 1
    run_frame("odd", 8'h03, 1'b1, PAR_ODD, 12'b1110_0000_0110, 1'b0);
    // FF odd parity: all ones after the start bit
    run_frame("ff", 8'hFF, 1'b1, PAR_ODD, 12'b1111_1111_1110, 1'b0);
    // held valid: first frame keeps A5 though P_data becomes 3C mid-frame
    run_frame("b2b1", 8'hA5, 1'b0, PAR_EVEN, 12'b1111_0100_1010, 1'b1);
    // second frame 3C: 0 | 0,0,1,1,1,1,0,0 | 1
    run_frame("b2b2", 8'h3C, 1'b0, PAR_EVEN, 12'b1110_0111_1000, 1'b0);

    // reset during data bit 4 (cycle 6) of an A5 frame
    bus.P_data     = 8'hA5;
    bus.PAR_EN     = 1'b0;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort bit4 tx", 32'(bus.TX_OUT), 32'd0);
    chk("abort bit4 busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    check_idle("abort async");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_idle("abort after");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Sequencer for the UART transmit datapath.
- Accepts a parallel byte on a valid strobe and latches it with the frame config.
- Serialises the frame LSB-first on TX_OUT: start, data, optional parity, stop.
- Flags busy for the whole frame. clk runs at the baud tick rate, so one clk period equals one bit time. Sits between the register/FIFO front end and the TX pin.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal range 5..9).

Ports:
- clk  in  1  bit-rate clock
- rst  in  1  asynchronous active-low reset
- data_valid  in  1  request: P_data is valid; sampled only in IDLE
- P_data  in  DATA_WIDTH  parallel data to send
- PAR_EN  in  1  parity bit inserted when 1; sampled at accept
- PAR_TYP  in  1  0 = even parity, 1 = odd parity; sampled at accept
- TX_OUT  out  1  serial line, registered, idle-high
- busy  out  1  frame in progress, registered
- frame_done  out  1  one-cycle pulse in the last stop-bit cycle

Behaviour:
- Reset: rst is asynchronous and active-low; clock is clk. While rst=0:
  - state=IDLE, TX_OUT=1, busy=0, frame_done=0.
  - Internal data register = 0, bit counter = 0.
  - Reset mid-frame aborts immediately; no partial frame resumes after release.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - If data_valid=1 at a clk edge: latch P_data, PAR_EN and PAR_TYP.
  - Compute parity from the latched data: even = ^data; odd = ~^data.
  - Next state START.
  - data_valid in any other state is ignored; nothing is queued.
- START: TX_OUT=0, busy=1, one cycle -> DATA.
- DATA:
  - TX_OUT = data[cnt], LSB first.
  - cnt runs 0..DATA_WIDTH-1.
  - At cnt=DATA_WIDTH-1: clear cnt, then go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: TX_OUT = latched parity bit, one cycle -> STOP.
- STOP: TX_OUT=1, frame_done=1 for exactly one cycle, then -> IDLE.
- Latency and timing:
  - Accept edge = cycle 0; start bit on TX_OUT during cycle 1.
  - Data bit k appears in cycle 2+k.
  - Frame length: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity.
- busy:
  - Registered; rises together with the start bit.
  - Falls on the cycle after STOP, i.e. IDLE has busy=0.
  - Minimum inter-frame gap is one IDLE cycle. A held data_valid is re-accepted in that IDLE cycle, giving back-to-back frames.
- Config stability: P_data, PAR_EN and PAR_TYP may change after accept without affecting the frame in flight.
- Outputs are glitch-free: TX_OUT is driven from a flop, not from the state decode.

Optional Feature:
- Macro UART_TX_TWO_STOP_EN.
- Defined:
  - STOP lasts two cycles, tracked with the bit counter.
  - frame_done pulses in the second stop cycle.
  - Frame length grows by 1.
- Undefined: single stop bit as above; no extra counter logic.

Decomposition:
- Package uart_tx_pkg:
  - state enum (IDLE/START/DATA/PARITY/STOP), 3-bit encoding.
  - Bit-value constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
  - Parity-type constants PAR_EVEN=0, PAR_ODD=1.
- Sub-module uart_tx_serializer: shift/index register with bit counter.
  - Loaded on accept, advanced in DATA; exposes ser_bit and ser_last.
  - The FSM in uart_tx_ctrl owns state, output mux, busy and frame_done.

Test Plan:
- Reset, then idle: hold rst=0 for 3 cycles, release with data_valid=0 for 5 cycles -> TX_OUT=1, busy=0, frame_done=0 throughout.
- No parity: P_data=8'hA5, PAR_EN=0, one-cycle data_valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 over cycles 1..10; busy=1 for cycles 1..10; frame_done only in cycle 10.
- Even parity:
  - P_data=8'h03, PAR_EN=1, PAR_TYP=0 -> parity bit 0 in cycle 10, stop in cycle 11.
  - Repeat with PAR_TYP=1 -> parity bit 1.
- Held valid, back-to-back: data_valid held high, P_data changed to 8'h3C mid-frame -> first frame still sends the originally latched byte; one IDLE cycle with TX_OUT=1, busy=0; second frame sends 8'h3C.
- Reset mid-frame: assert rst=0 during data bit 4 -> TX_OUT=1, busy=0 asynchronously; after release with data_valid=0, line stays idle.
- UART_TX_TWO_STOP_EN defined, P_data=8'hFF, PAR_EN=1, PAR_TYP=1 -> parity bit 1, then TX_OUT=1 for two stop cycles; frame_done in cycle 12; total frame length 12 cycles.
